// File: rtl/audio_clk_pkg.sv
// Shared types and default sizing for the audio clock / I2S receive path.
package audio_clk_pkg;

  localparam int unsigned DEF_DATA_W  = 24;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } frame_state_e;

endpackage

// File: rtl/bclk_edge_det.sv
// BCLK rise detection on the synchronized level, plus BCLK-loss watchdog.
module bclk_edge_det
  import audio_clk_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bclk_s,
  output logic rise_c,
  output logic lost_c,
  output logic clk_lost
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic             bclk_d;
  logic [CNT_W-1:0] idle_cnt;

  assign rise_c = bclk_s & ~bclk_d;
  // Fires on the TIMEOUT-th consecutive cycle without a rise; the held count stops repeats.
  assign lost_c = ~rise_c && (idle_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bclk_d   <= 1'b0;
      idle_cnt <= '0;
      clk_lost <= 1'b0;
    end else begin
      bclk_d <= bclk_s;
      if (rise_c) begin
        idle_cnt <= '0;
        clk_lost <= 1'b0;
      end else begin
        if (idle_cnt != CNT_W'(TIMEOUT)) begin
          idle_cnt <= idle_cnt + CNT_W'(1);
        end
        if (lost_c) begin
          clk_lost <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_frame_rx.sv
// I2S receiver: frames LRCK slots, deserializes MSB-first words, emits stereo samples.
module i2s_frame_rx
  import audio_clk_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bclk_s,
  input  logic              lrck_s,
  input  logic              sdata_s,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              sample_valid,
  output logic              locked,
  output logic              clk_lost
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 2);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              rise_c;
  logic              lost_c;
  logic              change_c;
  logic [IDX_W-1:0]  idx_c;

  frame_state_e      state;
  logic              lrck_d;
  logic [BIT_W-1:0]  bitcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_hold;

  bclk_edge_det #(
    .TIMEOUT (TIMEOUT)
  ) u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .bclk_s   (bclk_s),
    .rise_c   (rise_c),
    .lost_c   (lost_c),
    .clk_lost (clk_lost)
  );

  assign change_c = lrck_s ^ lrck_d;
  // Only meaningful while bitcnt < DATA_W, where the truncation is lossless.
  assign idx_c    = IDX_W'(DATA_W - 1) - IDX_W'(bitcnt);

  // Framing FSM and deserializer; acts only on BCLK rises, loss forces resync.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= HUNT;
      lrck_d       <= 1'b0;
      bitcnt       <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (lost_c) begin
        state  <= HUNT;
        locked <= 1'b0;
        bitcnt <= '0;
        shreg  <= '0;
      end else if (rise_c) begin
        lrck_d <= lrck_s;
        if (change_c) begin
          // Change rise carries the previous word's LSB delay bit: close the slot.
          bitcnt <= '0;
          shreg  <= '0;
          unique case (state)
            HUNT: begin
              if (!lrck_s) begin
                state <= LEFT;
              end
            end
            LEFT: begin
              left_hold <= shreg;
              state     <= RIGHT;
            end
            RIGHT: begin
              left_out     <= left_hold;
              right_out    <= shreg;
              sample_valid <= 1'b1;
              locked       <= 1'b1;
              state        <= LEFT;
            end
            default: state <= HUNT;
          endcase
        end else begin
          if (bitcnt < BIT_W'(DATA_W)) begin
            shreg[idx_c] <= sdata_s;
          end
          if (bitcnt != BIT_W'(DATA_W + 1)) begin
            bitcnt <= bitcnt + BIT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_rx.sv
// Directed bench for i2s_frame_rx: stimulus pushes expected samples, a monitor pops and compares.
module tb_i2s_frame_rx;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              bclk_s;
  logic              lrck_s;
  logic              sdata_s;
  logic [DATA_W-1:0] left_out;
  logic [DATA_W-1:0] right_out;
  logic              sample_valid;
  logic              locked;
  logic              clk_lost;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;

  logic [47:0] sb_q[$];
  logic [23:0] pend_l = '0;
  logic [23:0] pend_r = '0;

  i2s_frame_rx #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bclk_s       (bclk_s),
    .lrck_s       (lrck_s),
    .sdata_s      (sdata_s),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_valid (sample_valid),
    .locked       (locked),
    .clk_lost     (clk_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected sample and be one cycle wide.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1 && sample_valid === 1'b1) begin
      valid_cnt++;
      check("valid_width", 32'(prev_valid), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got L=%0h R=%0h want no sample", left_out, right_out);
      end else begin
        logic [47:0] e;
        e = sb_q.pop_front();
        check("sb_left", 32'(left_out), 32'(e[47:24]));
        check("sb_right", 32'(right_out), 32'(e[23:0]));
      end
    end
    prev_valid = sample_valid;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // One BCLK period: levels set while low, rise after 'half' clk cycles.
  task automatic drive_bit(input logic lr, input logic d, input int half);
    bclk_s  = 1'b0;
    lrck_s  = lr;
    sdata_s = d;
    repeat (half) @(negedge clk);
    bclk_s = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // One LRCK phase: delay bit, then 'slot' bits of w MSB-first; stops after nrises rises.
  task automatic phase(input logic lr, input logic [63:0] w, input int slot, input int half,
                       input int nrises);
    for (int k = 0; k <= slot && k < nrises; k++) begin
      logic d;
      d = (k == 0) ? 1'b0 : w[6'(slot - k)];
      drive_bit(lr, d, half);
    end
  endtask

  task automatic push_pend();
    sb_q.push_back({pend_l, pend_r});
  endtask

  // Full frame; when closes_prev, the frame's opening edge emits the previous frame.
  task automatic send_frame(input logic [63:0] lw, input logic [63:0] rw, input int slot,
                            input int half, input logic [23:0] exp_l, input logic [23:0] exp_r,
                            input bit closes_prev);
    if (closes_prev) push_pend();
    phase(1'b0, lw, slot, half, slot + 1);
    phase(1'b1, rw, slot, half, slot + 1);
    pend_l = exp_l;
    pend_r = exp_r;
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    bclk_s  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check({tag, "_left"}, 32'(left_out), 32'd0);
    check({tag, "_right"}, 32'(right_out), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_lost"}, 32'(clk_lost), 32'd0);
  endtask

  initial begin
    int base;
    int waited;
    reset_n = 1'b0;
    bclk_s  = 1'b0;
    lrck_s  = 1'b0;
    sdata_s = 1'b0;
    repeat (3) @(negedge clk);
    reset_pulse("rst0");

    // 32-bit slots at clk/8: frame 2 is the first one captured
    send_frame(64'hA5A5A500, 64'h3C3C3C00, 32, 4, 24'hA5A5A5, 24'h3C3C3C, 1'b0);
    send_frame(64'hA5A5A500, 64'h3C3C3C00, 32, 4, 24'hA5A5A5, 24'h3C3C3C, 1'b0);
    send_frame(64'hA5A5A500, 64'h3C3C3C00, 32, 4, 24'hA5A5A5, 24'h3C3C3C, 1'b1);
    check("s1_left", 32'(left_out), 32'hA5A5A5);
    check("s1_right", 32'(right_out), 32'h3C3C3C);
    check("s1_locked", 32'(locked), 32'd1);

    // 16-bit slots: zero-filled LSBs
    send_frame(64'hFFFF, 64'h1234, 16, 4, 24'hFFFF00, 24'h123400, 1'b1);
    send_frame(64'h0F0F, 64'hF0F0, 16, 4, 24'h0F0F00, 24'hF0F000, 1'b1);
    check("s2_left", 32'(left_out), 32'hFFFF00);
    check("s2_right", 32'(right_out), 32'h123400);

    // BCLK stops: loss only after TIMEOUT idle cycles, words retained
    repeat (40) @(negedge clk);
    check("loss_early", 32'(clk_lost), 32'd0);
    waited = 0;
    while (clk_lost !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("loss_flag", 32'(clk_lost), 32'd1);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_left", 32'(left_out), 32'hFFFF00);
    check("loss_right", 32'(right_out), 32'h123400);
    drive_bit(1'b1, 1'b0, 4);
    check("resume_lost", 32'(clk_lost), 32'd0);
    check("resume_locked", 32'(locked), 32'd0);
    send_frame(64'h5A5A5A, 64'hC3C3C3, 24, 4, 24'h5A5A5A, 24'hC3C3C3, 1'b0);
    send_frame(64'h111111, 64'h222222, 24, 4, 24'h111111, 24'h222222, 1'b1);
    check("resume_left", 32'(left_out), 32'h5A5A5A);
    check("resume_right", 32'(right_out), 32'hC3C3C3);
    check("resume_locked2", 32'(locked), 32'd1);

    // Reset in the middle of a left slot; the interrupted frame must never appear
    push_pend();
    phase(1'b0, 64'hABCDEF, 24, 4, 10);
    reset_pulse("rst_mid");

    // Stream starts mid-right-slot
    phase(1'b1, 64'h777777, 24, 2, 10);
    send_frame(64'h123456, 64'h654321, 24, 2, 24'h123456, 24'h654321, 1'b0);
    send_frame(64'h800001, 64'h000001, 24, 2, 24'h800001, 24'h000001, 1'b1);
    push_pend();
    phase(1'b0, 64'h0, 24, 2, 3);
    check("mid_left", 32'(left_out), 32'h800001);
    check("mid_right", 32'(right_out), 32'h000001);

    // 100 back-to-back frames at clk/4 with random data
    reset_pulse("rst_bulk");
    base = valid_cnt;
    for (int f = 0; f < 100; f++) begin
      logic [23:0] l;
      logic [23:0] r;
      l = 24'($urandom);
      r = 24'($urandom);
      send_frame(64'(l), 64'(r), 24, 2, l, r, f >= 2);
    end
    push_pend();
    phase(1'b0, 64'h0, 24, 2, 3);
    repeat (10) @(negedge clk);
    check("bulk_count", 32'(valid_cnt - base), 32'd99);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_frame_rx.md
# i2s_frame_rx

Recovers stereo PCM words from an external I2S link whose BCLK, LRCK and SDATA have already been brought into the system clock domain by the two-flop synchronizer stage. Consumes the synchronized levels and detects BCLK rising edges with a one-cycle history register. Deserializes left/right words and presents them as one-cycle-valid stereo samples to the audio clock mux. Also flags loss of BCLK so the mux can switch to a fallback source.

## Interface
Parameters:
- DATA_W, 24: captured word width per channel (MSB-first, left-aligned).
- TIMEOUT, 64: consecutive clk cycles without a BCLK rise before clock loss is declared; must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- bclk_s  in  1  synchronized BCLK level.
- lrck_s  in  1  synchronized LRCK level (0 = left, 1 = right).
- sdata_s  in  1  synchronized SDATA, same synchronizer depth as bclk_s/lrck_s.
- left_out  out  DATA_W  left word of last complete frame.
- right_out  out  DATA_W  right word of last complete frame.
- sample_valid  out  1  one-clk pulse; left_out/right_out updated in same cycle.
- locked  out  1  framing established; at least one frame emitted since last resync.
- clk_lost  out  1  BCLK absent for ≥ TIMEOUT clk cycles.

## Operation
- Rise event: bclk_s = 1 and bclk_d = 0 (bclk_d = bclk_s registered). All framing acts only on rise cycles.
- On each rise: sample lrck_s and sdata_s; lrck_d holds the lrck sampled at the previous rise.
- Change rise: rise where sampled lrck ≠ lrck_d. It carries the previous word's LSB delay bit (I2S one-bit delay) and is discarded as data.
- bitcnt: cleared on change rise, incremented on every other rise, saturates at DATA_W+1. On a non-change rise with 1 ≤ bitcnt+1 ≤ DATA_W, bit [DATA_W − (bitcnt+1)] of shreg takes sdata. MSB arrives at the first rise after a change rise.
- shreg cleared on every change rise after its contents are consumed. Short slots (fewer than DATA_W bits) yield zero-filled LSBs; long slots ignore extra bits.
- States: HUNT, LEFT, RIGHT.
  - HUNT: change rise with new lrck = 0 → LEFT; new lrck = 1 → stay HUNT.
  - LEFT: change rise (0→1) → left_hold ← shreg; → RIGHT.
  - RIGHT: change rise (1→0) → left_out ← left_hold, right_out ← shreg, sample_valid = 1, locked ← 1; → LEFT.
- Loss: idle counter increments every clk with no rise and clears on a rise. When it reaches TIMEOUT: clk_lost ← 1, locked ← 0, state ← HUNT, bitcnt/shreg cleared, and the counter holds at TIMEOUT. clk_lost clears on the next rise; that rise is treated as a HUNT rise.
- left_out/right_out hold their last value across loss; sample_valid is never asserted while in HUNT.
- Reset (reset_n = 0, highest priority, mid-frame included): state HUNT. All outputs, bclk_d, lrck_d, bitcnt, shreg, left_hold and the idle counter go to 0.

## Timing
- Outputs are registered; sample_valid is high in the cycle after the clk edge that sees the frame-closing change rise. Pad-to-valid = 2 synchronizer cycles + 1.
- sample_valid is exactly one clk wide; at most one per LRCK period.
- Input requirement: BCLK high and low phases each ≥ 2 clk cycles. The block is not required to handle faster BCLK.
- clk_lost rises on the TIMEOUT-th consecutive no-rise cycle, registered (visible one cycle later).

## Structure
- Package audio_clk_pkg: state enum (HUNT/LEFT/RIGHT), default DATA_W and TIMEOUT constants.
- One sub-module, bclk_edge_det: holds bclk_d, emits the rise strobe, and owns the idle counter and clk_lost. The framing FSM and deserializer live in the top.

## Test plan
- Reset then 3 frames, BCLK = clk/8, 32-bit slots, L = 0xA5A5A5, R = 0x3C3C3C → first sample_valid after frame 2's closing edge, left_out = 0xA5A5A5, right_out = 0x3C3C3C, locked = 1.
- Start stream mid-right-slot → no sample_valid until the full left+right pair following the first 1→0 change.
- 16-bit slots, L = 0xFFFF, R = 0x1234 → left_out = 0xFFFF00, right_out = 0x123400.
- Stop BCLK for 64 clk → clk_lost = 1, locked = 0, outputs retain last words. Resume → clk_lost clears on the first rise; valid only after the next full frame.
- Assert reset_n = 0 for 1 cycle mid-left-slot → all outputs 0 next cycle, no stale word emitted afterwards.
- Back-to-back frames at BCLK = clk/4 for 100 frames with random data → every word matches, exactly 100 − 1 valid pulses (first frame used for lock).
